// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: steps a WIDTH-bit count between captured low/high limits
// under a prescaler-generated tick enable. Modes: single-up, single-down,
// ping-pong, free-run wrap. Start/stop/pause control with one-cycle status
// pulses (done, wrap, err registered; tick decoded from the prescaler).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | not running; count holds, start accepted here only
//   ST_UP    | running, next step increments (mode 11: per dir_in)
//   ST_DOWN  | running, next step decrements (mode 11: per dir_in)
//   ST_PAUSE | running but frozen; resumes to UP/DOWN per dir register
module counter_sweep_ctrl #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter int DIV_W    = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic             dir_in,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [WIDTH-1:0] lim_hi,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             paused,
    output logic             tick,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SUP  = 2'b00;
    localparam logic [1:0] MODE_SDN  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_FREE = 2'b11;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             running;
    logic             tick_w;
    logic             go_up;

    // Step enable: only while actively stepping, at the prescaler terminal value.
    assign running = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign tick_w  = running && (presc_q == TICK_LAST);

    // Register bank; reset returns to IDLE with count 0 and direction up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            dir_q   <= 1'b1;
            presc_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= MODE_SUP;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Next-state, step arithmetic and pulse generation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        // Free-run takes its direction from dir_in at the tick itself.
        go_up   = (mode_q == MODE_FREE) ? dir_in : (state_q == ST_UP);

        case (state_q)
            ST_IDLE: begin
                // stop is the top-priority level, so it also blocks a start.
                if (start && !stop) begin
                    if (lim_lo <= lim_hi) begin
                        lo_d    = lim_lo;
                        hi_d    = lim_hi;
                        mode_d  = mode;
                        presc_d = '0;
                        case (mode)
                            MODE_SDN: begin
                                count_d = lim_hi;
                                dir_d   = 1'b0;
                                state_d = ST_DOWN;
                            end
                            MODE_FREE: begin
                                count_d = lim_lo;
                                dir_d   = dir_in;
                                state_d = dir_in ? ST_UP : ST_DOWN;
                            end
                            default: begin
                                count_d = lim_lo;
                                dir_d   = 1'b1;
                                state_d = ST_UP;
                            end
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_UP, ST_DOWN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    if (tick_w) begin
                        presc_d = '0;
                        if (go_up) begin
                            if (count_q < hi_q) begin
                                count_d = count_q + ONE;
                                dir_d   = 1'b1;
                                state_d = ST_UP;
                            end else begin
                                case (mode_q)
                                    MODE_PING: begin
                                        // Degenerate lo == hi range only flips direction.
                                        if (lo_q != hi_q) begin
                                            count_d = count_q - ONE;
                                        end
                                        dir_d   = 1'b0;
                                        state_d = ST_DOWN;
                                    end
                                    MODE_FREE: begin
                                        count_d = lo_q;
                                        wrap_d  = 1'b1;
                                        dir_d   = 1'b1;
                                        state_d = ST_UP;
                                    end
                                    default: begin
                                        done_d  = 1'b1;
                                        state_d = ST_IDLE;
                                    end
                                endcase
                            end
                        end else begin
                            if (count_q > lo_q) begin
                                count_d = count_q - ONE;
                                dir_d   = 1'b0;
                                state_d = ST_DOWN;
                            end else begin
                                case (mode_q)
                                    MODE_PING: begin
                                        if (lo_q != hi_q) begin
                                            count_d = count_q + ONE;
                                        end
                                        dir_d   = 1'b1;
                                        state_d = ST_UP;
                                    end
                                    MODE_FREE: begin
                                        count_d = hi_q;
                                        wrap_d  = 1'b1;
                                        dir_d   = 1'b0;
                                        state_d = ST_DOWN;
                                    end
                                    default: begin
                                        done_d  = 1'b1;
                                        state_d = ST_IDLE;
                                    end
                                endcase
                            end
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                    // A tick in the same cycle is applied first; a finished run stays idle.
                    if (pause && (state_d != ST_IDLE)) begin
                        state_d = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = dir_q ? ST_UP : ST_DOWN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output mapping.
    assign count  = count_q;
    assign dir    = dir_q;
    assign busy   = (state_q != ST_IDLE);
    assign paused = (state_q == ST_PAUSE);
    assign tick   = tick_w;
    assign done   = done_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with TICK_DIV=4. Expected step results
// are queued when a run is started and popped as each tick is applied.
module tb_counter_sweep_ctrl;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic [1:0]       mode;
    logic             dir_in;
    logic [WIDTH-1:0] lim_lo;
    logic [WIDTH-1:0] lim_hi;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             paused;
    logic             tick;
    logic             done;
    logic             wrap;
    logic             err;

    typedef struct {
        int         gap;
        logic [3:0] cnt;
        logic       d;
        logic       dn;
        logic       wr;
        logic       bz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    counter_sweep_ctrl #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV),
        .DIV_W   (DIV_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
        .dir_in(dir_in),
        .lim_lo(lim_lo),
        .lim_hi(lim_hi),
        .count (count),
        .dir   (dir),
        .busy  (busy),
        .paused(paused),
        .tick  (tick),
        .done  (done),
        .wrap  (wrap),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int gap, input int cnt, input logic d, input logic dn,
                        input logic wr, input logic bz);
        exp_t e;
        e.gap = gap;
        e.cnt = 4'(cnt);
        e.d   = d;
        e.dn  = dn;
        e.wr  = wr;
        e.bz  = bz;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next tick, let it apply, compare with the queue head.
    task automatic check_step(input string tag);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 40);
        chk({tag, " tick_seen"}, 32'(tick), 32'd1);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " gap"}, n, e.gap);
            chk({tag, " count"}, 32'(count), 32'(e.cnt));
            chk({tag, " dir"}, 32'(dir), 32'(e.d));
            chk({tag, " done"}, 32'(done), 32'(e.dn));
            chk({tag, " wrap"}, 32'(wrap), 32'(e.wr));
            chk({tag, " busy"}, 32'(busy), 32'(e.bz));
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int lo, input int hi, input logic di);
        @(negedge clk);
        mode   = m;
        lim_lo = 4'(lo);
        lim_hi = 4'(hi);
        dir_in = di;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk({tag, " busy_after_stop"}, 32'(busy), 32'd0);
    endtask

    task automatic run_single_up(input string tag);
        do_start(2'b00, 3, 6, 1'b1);
        chk({tag, " start_count"}, 32'(count), 32'd3);
        chk({tag, " start_busy"}, 32'(busy), 32'd1);
        push(4, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 6, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_step(tag);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " count_holds"}, 32'(count), 32'd6);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        pause  = 1'b0;
        mode   = 2'b00;
        dir_in = 1'b1;
        lim_lo = '0;
        lim_hi = '0;
        repeat (2) @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset dir", 32'(dir), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset paused", 32'(paused), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset pulses", {29'd0, done, wrap, err}, 32'd0);
        rst = 1'b0;

        // Single-up run
        run_single_up("s1");

        // Ping-pong 2..4
        do_start(2'b10, 2, 4, 1'b1);
        chk("s2 start_count", 32'(count), 32'd2);
        push(4, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        push(4, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        push(4, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) check_step("s2");
        do_stop("s2");

        // Ping-pong with lo == hi
        do_start(2'b10, 5, 5, 1'b1);
        chk("s2b start_count", 32'(count), 32'd5);
        push(4, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(4, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) check_step("s2b");
        do_stop("s2b");

        // Free-run down with wrap, then direction change between ticks
        do_start(2'b11, 0, 15, 1'b0);
        chk("s3 start_count", 32'(count), 32'd0);
        chk("s3 start_dir", 32'(dir), 32'd0);
        push(4, 15, 1'b0, 1'b0, 1'b1, 1'b1);
        push(4, 14, 1'b0, 1'b0, 1'b0, 1'b1);
        push(4, 13, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) check_step("s3");
        dir_in = 1'b1;
        @(negedge clk);
        chk("s3 dir_between_ticks", 32'(dir), 32'd0);
        chk("s3 count_between_ticks", 32'(count), 32'd13);
        push(3, 14, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        push(4, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) check_step("s3u");
        do_stop("s3");

        // Pause mid-period, then stop coinciding with a tick
        do_start(2'b00, 0, 15, 1'b1);
        push(4, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_step("s4");
        @(negedge clk);
        @(negedge clk);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        chk("s4 paused", 32'(paused), 32'd1);
        chk("s4 frozen_count", 32'(count), 32'd1);
        chk("s4 no_tick_in_pause", 32'(tick), 32'd0);
        chk("s4 busy_in_pause", 32'(busy), 32'd1);
        pause = 1'b0;
        push(2, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        check_step("s4r");
        chk("s4 paused_released", 32'(paused), 32'd0);
        repeat (4) @(negedge clk);
        chk("s4 tick_at_stop", 32'(tick), 32'd1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("s4 stop_busy", 32'(busy), 32'd0);
        chk("s4 stop_count", 32'(count), 32'd2);
        chk("s4 stop_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("s4 stop_done_later", 32'(done), 32'd0);

        // Rejected start
        do_start(2'b00, 9, 4, 1'b1);
        chk("s5 err", 32'(err), 32'd1);
        chk("s5 busy", 32'(busy), 32'd0);
        chk("s5 count", 32'(count), 32'd2);
        @(posedge clk);
        #1;
        chk("s5 err_one_cycle", 32'(err), 32'd0);

        // Asynchronous reset mid-run, then a normal single-up run
        do_start(2'b10, 2, 4, 1'b1);
        push(4, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        check_step("s6");
        #2;
        rst = 1'b1;
        #1;
        chk("s6 rst_count", 32'(count), 32'd0);
        chk("s6 rst_dir", 32'(dir), 32'd1);
        chk("s6 rst_busy", 32'(busy), 32'd0);
        chk("s6 rst_pulses", {28'd0, tick, done, wrap, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_single_up("s6r");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the 4-bit up/down display counter.
- Replaces the free-running divided clock with a single-clock tick enable, which the block generates from an internal prescaler.
- Steps a count between programmable low/high limits in one of four modes: single-up, single-down, ping-pong, free-run wrap.
- Provides start, stop and pause control with status pulses. Sits between the board switches/buttons and the display driver.

Parameters:
- WIDTH, 4, count and limit width.
- TICK_DIV, 25_000_000, clk cycles per count step (min 2).
- DIV_W, 25, prescaler width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a run; sampled in IDLE only.
- stop  input  1  abort the run; level, highest priority.
- pause  input  1  level; freezes stepping while high.
- mode  input  2  00 single-up, 01 single-down, 10 ping-pong, 11 free-run.
- dir_in  input  1  free-run direction (1 = up); sampled on each tick.
- lim_lo  input  WIDTH  lower limit; captured at start.
- lim_hi  input  WIDTH  upper limit; captured at start.
- count  output  WIDTH  current count value.
- dir  output  1  current direction (1 = up).
- busy  output  1  high whenever state != IDLE.
- paused  output  1  high in PAUSE.
- tick  output  1  one-cycle step-enable pulse.
- done  output  1  one-cycle pulse at the end of a single-up or single-down run.
- wrap  output  1  one-cycle pulse on a free-run wrap.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:

Clock and reset:
- Single clock; all registers update on posedge clk.
- Async reset values: state IDLE; count 0; dir 1; prescaler 0; captured limits 0; busy, paused, tick, done, wrap, err all 0.
- Reset mid-run aborts immediately; no done pulse is produced.

States: IDLE, UP, DOWN, PAUSE. The active direction is held in the dir register.

IDLE:
- start=1 with lim_lo <= lim_hi: capture both limits, clear the prescaler, and on the next edge move to the start state below. busy=1 from that same edge.
  - Mode 00: count=lo, UP.
  - Mode 01: count=hi, DOWN.
  - Mode 10: count=lo, UP.
  - Mode 11: count=lo, and go to UP or DOWN per dir_in.
- start=1 with lim_lo > lim_hi: stay in IDLE, err=1 for one cycle, count unchanged.
- In IDLE, count holds its last value.

Prescaler:
- Counts only in UP and DOWN; frozen in PAUSE and IDLE.
- tick=1 in the cycle where prescaler == TICK_DIV-1; the prescaler then wraps to 0.
- First tick occurs TICK_DIV cycles after the start edge.

On tick in UP:
- count < hi: count+1.
- count == hi, mode 00: done=1, go to IDLE, count stays hi.
- count == hi, mode 10: go to DOWN, dir=0, count = hi-1. If lo == hi, count is held and only the direction flips.
- count == hi, mode 11: count=lo, wrap=1.

On tick in DOWN: mirror image of UP.
- Mode 01 ends at lo with done=1.
- Mode 10 turns at lo to UP with count lo+1.
- Mode 11 wraps lo -> hi with wrap=1.

Free-run direction (mode 11):
- dir_in is sampled on each tick and takes effect on that same step.
- Changing dir_in between ticks has no effect until the next tick.

Pause:
- pause=1 in UP or DOWN: go to PAUSE on the next edge; count and prescaler are frozen; paused=1.
- pause=0: return to the state indicated by dir; the prescaler resumes from its frozen value.
- A tick coinciding with the pause assertion is still applied.

Stop:
- stop=1 in any non-IDLE state: go to IDLE on the next edge; count held; done not asserted.
- stop overrides a simultaneous tick or pause.
- start asserted while busy is ignored.

Width rules:
- All count arithmetic is WIDTH bits; limits bound every step.
- count never leaves [lo, hi] while busy.

Test Plan (TICK_DIV=4):
1. mode 00, lo=3, hi=6, start -> count 3, 4, 5, 6 at 4-cycle spacing; done pulse on the 4th tick; busy drops on the same edge; count stays 6.
2. mode 10, lo=2, hi=4 -> count sequence 2, 3, 4, 3, 2, 3, 4; dir toggles at 4 and at 2; no done. Then lo=hi=5 -> count stays 5 and dir toggles on every tick.
3. mode 11, lo=0, hi=15, dir_in=0 -> 0, 15 (wrap=1), 14, ...; flip dir_in to 1 mid-period -> next tick steps up.
4. Pause held for 10 cycles in the middle of a period -> count and prescaler frozen, paused=1; after release, the next tick arrives after the remaining prescaler cycles only. Assert stop together with a tick -> IDLE, count not stepped, no done.
5. start with lo=9, hi=4 -> err pulse, busy stays 0, count unchanged.
6. Assert rst mid-run in mode 10 -> all outputs return to reset values asynchronously. A start after release behaves exactly as in scenario 1.
